// File: rtl/imem_loadable_if.sv
// Load and fetch bus of the loadable instruction memory.
// master = program loader / fetch unit, slave = imem_loadable.
interface imem_loadable_if #(
  parameter int IW = 9,
  parameter int AW = 8
);
  logic          load_start;
  logic          load_valid;
  logic          load_ready;
  logic [IW-1:0] load_data;
  logic          load_last;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic [IW-1:0] instr;
  logic          instr_valid;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
    input  load_ready, instr, instr_valid
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
    output load_ready, instr, instr_valid
  );
endinterface

// File: rtl/imem_loadable.sv
// Loadable instruction memory: valid/ready sequential load, 1-cycle registered fetch.
// Load stalls only outside LOAD (load_ready=0); fetches are serviced only in RUN.
module imem_loadable #(
  parameter int            IW  = 9,
  parameter int            AW  = 8,
  parameter logic [IW-1:0] NOP = '0
) (
  input  logic              clk,
  input  logic              reset,
  imem_loadable_if.slave    bus,
  output logic              done,
  output logic [AW:0]       prog_len,
  output logic              ready,
  output logic              load_ovf
);

  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

  state_t        state;
  logic [AW:0]   wp;
  logic [IW-1:0] mem [DEPTH];

  logic wr_en;
  logic in_range;

  // load_start in LOAD takes priority: the word presented alongside it is dropped.
  assign wr_en    = (state == LOAD) && bus.load_valid && !bus.load_start;
  assign in_range = ({1'b0, bus.fetch_addr} < prog_len);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp[AW-1:0]] <= bus.load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= EMPTY;
      wp              <= '0;
      prog_len        <= '0;
      done            <= 1'b0;
      load_ovf        <= 1'b0;
      ready           <= 1'b0;
      bus.load_ready  <= 1'b0;
      bus.instr       <= NOP;
      bus.instr_valid <= 1'b0;
    end else begin
      bus.instr_valid <= 1'b0;
      case (state)
        EMPTY: begin
          if (bus.load_start) begin
            state          <= LOAD;
            bus.load_ready <= 1'b1;
            wp             <= '0;
            done           <= 1'b0;
            load_ovf       <= 1'b0;
          end
        end

        LOAD: begin
          if (bus.load_start) begin
            wp <= '0;
          end else if (bus.load_valid) begin
            wp <= wp + ONE;
            if (bus.load_last) begin
              state          <= RUN;
              ready          <= 1'b1;
              bus.load_ready <= 1'b0;
              prog_len       <= wp + ONE;
            end else if (wp == LAST) begin
              // Memory full without an end marker: run what we have and flag it.
              state          <= RUN;
              ready          <= 1'b1;
              bus.load_ready <= 1'b0;
              prog_len       <= FULL;
              load_ovf       <= 1'b1;
            end
          end
        end

        RUN: begin
          if (bus.fetch_req) begin
            bus.instr_valid <= 1'b1;
            bus.instr       <= in_range ? mem[bus.fetch_addr] : NOP;
            if (!in_range) begin
              done <= 1'b1;
            end
          end
          // A fetch issued with load_start still completes against the old program.
          if (bus.load_start) begin
            state          <= LOAD;
            ready          <= 1'b0;
            bus.load_ready <= 1'b1;
            wp             <= '0;
            prog_len       <= '0;
            done           <= 1'b0;
            load_ovf       <= 1'b0;
          end
        end

        default: begin
          state          <= EMPTY;
          ready          <= 1'b0;
          bus.load_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable: directed plan plus randomized programs
// checked against a queue-based model of the loaded program.
module tb_imem_loadable;
  localparam int            IW  = 9;
  localparam int            AW  = 8;
  localparam int            AW3 = 3;
  localparam logic [IW-1:0] NOP = '0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loadable_if #(.IW(IW), .AW(AW))  bus ();
  imem_loadable_if #(.IW(IW), .AW(AW3)) bus3 ();

  logic          done, ready, load_ovf;
  logic [AW:0]   prog_len;
  logic          done3, ready3, load_ovf3;
  logic [AW3:0]  prog_len3;

  imem_loadable #(.IW(IW), .AW(AW), .NOP(NOP)) u_dut (
    .clk(clk), .reset(reset), .bus(bus),
    .done(done), .prog_len(prog_len), .ready(ready), .load_ovf(load_ovf)
  );

  imem_loadable #(.IW(IW), .AW(AW3), .NOP(NOP)) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus3),
    .done(done3), .prog_len(prog_len3), .ready(ready3), .load_ovf(load_ovf3)
  );

  // Reference model: the program is simply the list of accepted words.
  logic [IW-1:0] prog[$];
  bit            done_m;
  logic [IW-1:0] last_instr;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input logic [IW-1:0] words[$], input bit gaps, input bit noise);
    bus.load_start = 1'b1;
    bus.load_valid = 1'b0;
    bus.fetch_req  = 1'b0;
    tick();
    bus.load_start = 1'b0;
    prog.delete();
    done_m = 1'b0;
    check("load_ready_in_load", 32'(bus.load_ready), 32'd1);
    check("prog_len_in_load", 32'(prog_len), 32'd0);
    foreach (words[i]) begin
      if (gaps) begin
        bus.load_valid = 1'b0;
        bus.load_data  = IW'($urandom);
        bus.fetch_req  = noise;
        bus.fetch_addr = AW'($urandom);
        tick();
        check("gap_instr_valid", 32'(bus.instr_valid), 32'd0);
      end
      bus.load_valid = 1'b1;
      bus.load_data  = words[i];
      bus.load_last  = (i == words.size() - 1);
      bus.fetch_req  = noise;
      bus.fetch_addr = AW'($urandom);
      tick();
      check("load_instr_valid", 32'(bus.instr_valid), 32'd0);
      prog.push_back(words[i]);
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.fetch_req  = 1'b0;
    check("prog_len", 32'(prog_len), 32'(prog.size()));
    check("ready_run", 32'(ready), 32'd1);
    check("load_ready_run", 32'(bus.load_ready), 32'd0);
    check("done_after_load", 32'(done), 32'd0);
    check("load_ovf_after_load", 32'(load_ovf), 32'd0);
  endtask

  task automatic fetch(input int addr);
    logic [IW-1:0] exp;
    exp = (addr < prog.size()) ? prog[addr] : NOP;
    if (addr >= prog.size()) done_m = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = AW'(addr);
    tick();
    bus.fetch_req  = 1'b0;
    check("fetch_valid", 32'(bus.instr_valid), 32'd1);
    check("fetch_instr", 32'(bus.instr), 32'(exp));
    check("fetch_done", 32'(done), 32'(done_m));
    last_instr = exp;
  endtask

  task automatic idle();
    tick();
    check("idle_valid", 32'(bus.instr_valid), 32'd0);
    check("idle_hold", 32'(bus.instr), 32'(last_instr));
  endtask

  logic [IW-1:0] w[$];
  logic [IW-1:0] q3[$];

  initial begin
    reset = 1'b1;
    bus.load_start = 0; bus.load_valid = 0; bus.load_data = '0; bus.load_last = 0;
    bus.fetch_req = 0; bus.fetch_addr = '0;
    bus3.load_start = 0; bus3.load_valid = 0; bus3.load_data = '0; bus3.load_last = 0;
    bus3.fetch_req = 0; bus3.fetch_addr = '0;
    #1;
    check("rst_prog_len", 32'(prog_len), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_load_ready", 32'(bus.load_ready), 32'd0);
    check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", 32'(bus.instr), 32'(NOP));
    check("rst_done", 32'(done), 32'd0);
    check("rst_load_ovf", 32'(load_ovf), 32'd0);
    tick();
    reset = 1'b0;

    // Fetch while EMPTY is ignored.
    bus.fetch_req = 1'b1; bus.fetch_addr = AW'(7);
    tick();
    bus.fetch_req = 1'b0;
    check("empty_fetch_valid", 32'(bus.instr_valid), 32'd0);
    check("empty_fetch_done", 32'(done), 32'd0);

    // Test 1 and 2.
    w = '{9'h10F, 9'h10F, 9'h1A3, 9'h0A9, 9'h198};
    load_prog(w, 1'b0, 1'b0);
    for (int a = 0; a < 5; a++) fetch(a);
    idle();
    fetch(5);
    fetch(2);
    idle();

    // Test 3: load_valid every other cycle, fetch noise during load.
    w = '{9'h011, 9'h122, 9'h033};
    load_prog(w, 1'b1, 1'b1);
    for (int a = 0; a < 4; a++) fetch(a);

    // Test 5: load_start with a fetch in RUN.
    bus.load_start = 1'b1; bus.fetch_req = 1'b1; bus.fetch_addr = AW'(1);
    tick();
    bus.load_start = 1'b0; bus.fetch_req = 1'b0;
    check("ls_fetch_valid", 32'(bus.instr_valid), 32'd1);
    check("ls_fetch_instr", 32'(bus.instr), 32'(prog[1]));
    check("ls_prog_len", 32'(prog_len), 32'd0);
    check("ls_done", 32'(done), 32'd0);
    check("ls_ready", 32'(ready), 32'd0);
    check("ls_load_ready", 32'(bus.load_ready), 32'd1);
    w = '{9'h1C4, 9'h0D5};
    load_prog(w, 1'b0, 1'b0);
    for (int a = 0; a < 3; a++) fetch(a);

    // load_start with a valid word in LOAD: word dropped, wp restarts.
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b1; bus.load_valid = 1'b1; bus.load_data = 9'h1FF; bus.load_last = 1'b0;
    tick();
    bus.load_start = 1'b0; bus.load_data = 9'h077; bus.load_last = 1'b1;
    tick();
    bus.load_valid = 1'b0; bus.load_last = 1'b0;
    prog.delete(); prog.push_back(9'h077); done_m = 1'b0;
    check("restart_prog_len", 32'(prog_len), 32'd1);
    fetch(0);
    fetch(1);

    // Randomized programs.
    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(1, 24);
      w.delete();
      for (int i = 0; i < len; i++) w.push_back(IW'($urandom));
      load_prog(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 3) == 0) idle();
        fetch($urandom_range(0, len + 3));
      end
    end

    // Test 4: AW=3 instance fills memory without load_last.
    bus3.load_start = 1'b1;
    tick();
    bus3.load_start = 1'b0;
    for (int i = 0; i < 8; i++) q3.push_back(IW'($urandom_range(1, 511)));
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("ovf_not_run_yet", 32'(ready3), 32'd0);
      bus3.load_valid = 1'b1; bus3.load_data = q3[i]; bus3.load_last = 1'b0;
      tick();
    end
    bus3.load_valid = 1'b0;
    check("ovf_ready", 32'(ready3), 32'd1);
    check("ovf_prog_len", 32'(prog_len3), 32'd8);
    check("ovf_flag", 32'(load_ovf3), 32'd1);
    check("ovf_load_ready", 32'(bus3.load_ready), 32'd0);
    bus3.fetch_req = 1'b1; bus3.fetch_addr = AW3'(7);
    tick();
    bus3.fetch_req = 1'b0;
    check("ovf_fetch_valid", 32'(bus3.instr_valid), 32'd1);
    check("ovf_fetch_instr", 32'(bus3.instr), 32'(q3[7]));
    check("ovf_fetch_done", 32'(done3), 32'd0);
    bus3.load_start = 1'b1;
    tick();
    bus3.load_start = 1'b0;
    check("ovf_cleared", 32'(load_ovf3), 32'd0);
    check("ovf_len_cleared", 32'(prog_len3), 32'd0);

    // Test 6: asynchronous reset mid-load.
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.load_valid = 1'b1; bus.load_data = IW'(9'h100 + i); bus.load_last = 1'b0;
      tick();
    end
    check("pre_rst_instr", 32'(bus.instr), 32'(9'h077 == last_instr ? last_instr : last_instr));
    #2;
    reset = 1'b1;
    #1;
    check("arst_prog_len", 32'(prog_len), 32'd0);
    check("arst_load_ready", 32'(bus.load_ready), 32'd0);
    check("arst_ready", 32'(ready), 32'd0);
    check("arst_instr", 32'(bus.instr), 32'(NOP));
    check("arst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_load_ovf", 32'(load_ovf), 32'd0);
    bus.load_valid = 1'b0;
    tick();
    reset = 1'b0;
    bus.fetch_req = 1'b1; bus.fetch_addr = AW'(0);
    tick();
    bus.fetch_req = 1'b0;
    check("post_rst_fetch_valid", 32'(bus.instr_valid), 32'd0);
    check("post_rst_ready", 32'(ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
